// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared channel state encoding and stat counter width
package clk_gate_pkg;
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } gate_state_t;
  localparam int STAT_W = 16;
endpackage

// File: rtl/clk_gate_chan.sv
// clk_gate_chan: one channel's wake/idle FSM driving its clock gate and ack
module clk_gate_chan
  import clk_gate_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              act,
  input  logic [IDLE_W-1:0] cfg_idle,
  output logic              gate_en,
  output logic              ack
);
  localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  gate_state_t       state, state_nxt;
  logic [WW-1:0]     wake_cnt, wake_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  // state and both countdowns; async reset drops the clock immediately
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= OFF;
      wake_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_nxt;
      idle_cnt <= idle_nxt;
    end
  end
  // wake finishes even if activity vanishes; activity in IDLE beats timeout
  always_comb begin
    state_nxt = state;
    wake_nxt  = wake_cnt;
    idle_nxt  = idle_cnt;
    case (state)
      OFF: if (act) begin
        state_nxt = WAKE;
        wake_nxt  = WW'(WAKE_CYC - 1);
      end
      WAKE: if (wake_cnt == '0) state_nxt = ON;
            else wake_nxt = wake_cnt - 1'b1;
      ON: if (!act) begin
        state_nxt = IDLE;
        idle_nxt  = cfg_idle;
      end
      IDLE: if (act) state_nxt = ON;
            else if (idle_cnt == '0) state_nxt = OFF;
            else idle_nxt = idle_cnt - 1'b1;
      default: state_nxt = OFF;
    endcase
  end
  assign gate_en = state != OFF;
  assign ack     = (state == ON) || (state == IDLE);
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel clock-enable scheduler; CLK_GATE_CTRL_STAT_EN adds gated-cycle counters
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   busy,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] cfg_idle,
  output logic [N_CH-1:0]   gate_en,
  output logic [N_CH-1:0]   ack,
  input  logic [SEL_W-1:0]  stat_sel,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_cnt
);
  logic [N_CH-1:0] chan_gate;
  logic            force_q;
  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_gate_chan #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) u_chan (
      .clk     (clk),
      .rst_b   (rst_b),
      .act     (req[g] | busy[g]),
      .cfg_idle(cfg_idle),
      .gate_en (chan_gate[g]),
      .ack     (ack[g])
    );
  end
  // override is registered so gate_en stays a clean flop-driven enable
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) force_q <= 1'b0;
    else force_q <= force_on;
  end
  assign gate_en = chan_gate | {N_CH{force_q}};
`ifdef CLK_GATE_CTRL_STAT_EN
  logic [STAT_W-1:0] cnt [N_CH];
  // saturating gated-cycle counters; clear beats increment; readout lags one cycle
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_cnt <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      stat_cnt <= cnt[stat_sel];
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= stat_clr ? '0 : (!gate_en[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_cnt    = '0;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed scenarios plus randomized run against a timestamp-based reference model
module tb_clk_gate_ctrl;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int WC = 2;
  logic          clk = 1'b0;
  logic          rst_b;
  logic [N-1:0]  req = '0, busy = '0;
  logic          force_on = 1'b0;
  logic [IW-1:0] cfg_idle = '0;
  logic [N-1:0]  gate_en, ack;
  logic [1:0]    stat_sel = '0;
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_cnt;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(.N_CH(N), .IDLE_W(IW), .WAKE_CYC(WC)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .busy(busy), .force_on(force_on),
    .cfg_idle(cfg_idle), .gate_en(gate_en), .ack(ack), .stat_sel(stat_sel),
    .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  // reference: a channel is powered from its wake edge, acked WC edges later,
  // and unpowered on the (cfg+2)-th consecutive quiet edge after acking
  int edge_n = 0;
  bit m_pow [N], m_ack [N], m_force;
  int m_wake [N], m_quiet [N], m_cfg [N], m_stat [N], m_stat_out;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < N; i++) begin
        m_pow[i] = 0; m_ack[i] = 0; m_quiet[i] = 0; m_stat[i] = 0;
      end
      m_force = 0;
      m_stat_out = 0;
    end else begin
      edge_n++;
      m_stat_out = m_stat[stat_sel];
      for (int i = 0; i < N; i++)
        if (stat_clr) m_stat[i] = 0;
        else if (!(m_pow[i] || m_force) && m_stat[i] < 65535) m_stat[i]++;
      for (int i = 0; i < N; i++) begin
        if (!m_pow[i]) begin
          if (req[i] | busy[i]) begin m_pow[i] = 1; m_wake[i] = edge_n; end
        end else if (!m_ack[i]) begin
          if (edge_n - m_wake[i] == WC) begin m_ack[i] = 1; m_quiet[i] = 0; end
        end else if (req[i] | busy[i]) m_quiet[i] = 0;
        else begin
          m_quiet[i]++;
          if (m_quiet[i] == 1) m_cfg[i] = int'(cfg_idle);
          if (m_quiet[i] == m_cfg[i] + 2) begin m_pow[i] = 0; m_ack[i] = 0; end
        end
      end
      m_force = force_on;
    end
  end

  logic [N-1:0] e_gate, e_ack;
  always_comb begin
    e_gate = '0;
    e_ack  = '0;
    for (int i = 0; i < N; i++) begin
      e_gate[i] = m_pow[i] | m_force;
      e_ack[i]  = m_ack[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #2;
    n_cmp++; if (gate_en !== 4'h0) begin n_err++; $display("FAIL reset_gate: got %h want 0", gate_en); end
    n_cmp++; if (ack !== 4'h0) begin n_err++; $display("FAIL reset_ack: got %h want 0", ack); end
    n_cmp++; if (stat_cnt !== 16'h0) begin n_err++; $display("FAIL reset_stat: got %h want 0", stat_cnt); end
    repeat (3) step();
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_wake();
    req[0] = 1'b1;
    n_cmp++; if (gate_en !== 4'h0) begin n_err++; $display("FAIL wake_pre_gate: got %h want 0", gate_en); end
    step();
    n_cmp++; if (gate_en !== 4'h1 || ack !== 4'h0) begin n_err++; $display("FAIL wake_gate: got gate=%h ack=%h want 1/0", gate_en, ack); end
    step();
    n_cmp++; if (ack !== 4'h0) begin n_err++; $display("FAIL wake_ack_early: got %h want 0", ack); end
    step();
    n_cmp++; if (ack !== 4'h1 || gate_en !== 4'h1) begin n_err++; $display("FAIL wake_ack: got gate=%h ack=%h want 1/1", gate_en, ack); end
  endtask

  task automatic test_idle_timeout();
    cfg_idle = 8'd3;
    req[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) cfg_idle = 8'd200;
      n_cmp++;
      if (gate_en[0] !== (k < 5) || ack[0] !== (k < 5)) begin
        n_err++; $display("FAIL idle_timeout_%0d: got gate=%b ack=%b want %b", k, gate_en[0], ack[0], k < 5);
      end
    end
  endtask

  task automatic test_idle_reassert();
    cfg_idle = 8'd0;
    req[1] = 1'b1;
    repeat (WC + 1) step();
    n_cmp++; if (ack !== 4'h2) begin n_err++; $display("FAIL reassert_on: got %h want 2", ack); end
    req[1] = 1'b0;
    step();
    n_cmp++; if (gate_en !== 4'h2 || ack !== 4'h2) begin n_err++; $display("FAIL reassert_idle: got gate=%h ack=%h want 2/2", gate_en, ack); end
    req[1] = 1'b1;
    step();
    n_cmp++; if (gate_en !== 4'h2 || ack !== 4'h2) begin n_err++; $display("FAIL reassert_win: got gate=%h ack=%h want 2/2", gate_en, ack); end
    step();
    n_cmp++; if (gate_en !== 4'h2 || ack !== 4'h2) begin n_err++; $display("FAIL reassert_hold: got gate=%h ack=%h want 2/2", gate_en, ack); end
    req[1] = 1'b0;
    step();
    n_cmp++; if (gate_en !== 4'h2) begin n_err++; $display("FAIL cfg0_idle: got %h want 2", gate_en); end
    step();
    n_cmp++; if (gate_en !== 4'h0 || ack !== 4'h0) begin n_err++; $display("FAIL cfg0_off: got gate=%h ack=%h want 0/0", gate_en, ack); end
  endtask

  task automatic test_force();
    force_on = 1'b1;
    step();
    n_cmp++; if (gate_en !== 4'hF || ack !== 4'h0) begin n_err++; $display("FAIL force_on: got gate=%h ack=%h want F/0", gate_en, ack); end
    force_on = 1'b0;
    step();
    n_cmp++; if (gate_en !== 4'h0) begin n_err++; $display("FAIL force_off: got %h want 0", gate_en); end
  endtask

  task automatic test_async_reset();
    req[2] = 1'b1;
    step();
    n_cmp++; if (gate_en !== 4'h4) begin n_err++; $display("FAIL arst_wake_pre: got %h want 4", gate_en); end
    rst_b = 1'b0;
    #1;
    n_cmp++; if (gate_en !== 4'h0 || ack !== 4'h0) begin n_err++; $display("FAIL arst_wake: got gate=%h ack=%h want 0/0", gate_en, ack); end
    req = '0;
    #2 rst_b = 1'b1;
    repeat (2) step();
    n_cmp++; if (gate_en !== 4'h0 || ack !== 4'h0) begin n_err++; $display("FAIL arst_wake_after: got gate=%h ack=%h want 0/0", gate_en, ack); end
    req[3] = 1'b1;
    cfg_idle = 8'd5;
    repeat (WC + 1) step();
    req[3] = 1'b0;
    step();
    n_cmp++; if (gate_en !== 4'h8 || ack !== 4'h8) begin n_err++; $display("FAIL arst_idle_pre: got gate=%h ack=%h want 8/8", gate_en, ack); end
    rst_b = 1'b0;
    #1;
    n_cmp++; if (gate_en !== 4'h0 || ack !== 4'h0) begin n_err++; $display("FAIL arst_idle: got gate=%h ack=%h want 0/0", gate_en, ack); end
    #2 rst_b = 1'b1;
    repeat (3) step();
    n_cmp++; if (gate_en !== 4'h0 || ack !== 4'h0) begin n_err++; $display("FAIL arst_idle_after: got gate=%h ack=%h want 0/0", gate_en, ack); end
  endtask

`ifdef CLK_GATE_CTRL_STAT_EN
  task automatic test_stat();
    stat_sel = 2'd2;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    repeat (70000) step();
    n_cmp++; if (stat_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stat_sat: got %h want FFFF", stat_cnt); end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    step();
    n_cmp++; if (stat_cnt !== 16'h0) begin n_err++; $display("FAIL stat_clr: got %h want 0", stat_cnt); end
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      if ($urandom_range(0, 9) == 0) busy = N'($urandom) & N'($urandom);
      force_on = ($urandom_range(0, 15) == 0);
      cfg_idle = IW'($urandom_range(0, 6));
      stat_sel = 2'($urandom);
      stat_clr = ($urandom_range(0, 63) == 0);
      step();
      n_cmp++; if (gate_en !== e_gate) begin n_err++; $display("FAIL rand_gate t=%0d: got %h want %h", t, gate_en, e_gate); end
      n_cmp++; if (ack !== e_ack) begin n_err++; $display("FAIL rand_ack t=%0d: got %h want %h", t, ack, e_ack); end
`ifdef CLK_GATE_CTRL_STAT_EN
      n_cmp++; if (stat_cnt !== 16'(m_stat_out)) begin n_err++; $display("FAIL rand_stat t=%0d: got %h want %h", t, stat_cnt, 16'(m_stat_out)); end
`else
      n_cmp++; if (stat_cnt !== 16'h0) begin n_err++; $display("FAIL rand_stat t=%0d: got %h want 0", t, stat_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_idle_timeout();
    test_idle_reassert();
    test_force();
    test_async_reset();
`ifdef CLK_GATE_CTRL_STAT_EN
    test_stat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
